// File: rtl/dlx_bus_mac.sv
// dlx_bus_mac: memory-access controller for the DLX core. Turns a one-cycle
// read/write request into an asynchronous-slave bus cycle (AS_N/WR_N/ACK_N).
// It supports optional address-setup wait states and a bounded ACK timeout
// with a sticky error flag. Address, write data and read data are latched.
module dlx_bus_mac #(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int SETUP_CYC = 0,    // 0..15 address-setup cycles before strobe
   parameter int TIMEOUT   = 255,  // WAIT cycles without ACK before abort; 0 = never
   parameter int TO_W      = 8     // timeout counter width, TIMEOUT < 2**TO_W
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          REQ,
   input  logic          MR,
   input  logic          MW,
   input  logic [AW-1:0] addr_in,
   input  logic [DW-1:0] wdata_in,
   input  logic          ACK_N,
   input  logic [DW-1:0] bus_din,
   input  logic          err_clr,
   output logic          AS_N,
   output logic          WR_N,
   output logic [AW-1:0] bus_addr,
   output logic [DW-1:0] bus_dout,
   output logic [DW-1:0] rdata,
   output logic          busy,
   output logic          done,
   output logic          timeout_err,
   output logic [2:0]    STATE
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_WAIT  = 3'd2,
      S_DONE  = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   localparam logic [3:0]      SETUP_LAST = (SETUP_CYC > 0) ? 4'(SETUP_CYC - 1) : 4'd0;
   localparam logic [TO_W-1:0] TO_LAST    = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;
   localparam bit              TO_EN      = (TIMEOUT != 0);

   state_t          state, state_nx;
   logic            wr;          // latched direction of the current access
   logic            done_first;  // high only in the first DONE cycle
   logic [3:0]      setup_cnt;
   logic [TO_W-1:0] to_cnt;

   logic accept, ack, setup_last, to_hit;

   assign accept     = REQ & (MR | MW);
   assign ack        = ~ACK_N;
   assign setup_last = (setup_cnt == SETUP_LAST);
   assign to_hit     = TO_EN && (to_cnt == TO_LAST);

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking (<=) so every register samples
      // the pre-edge values and process ordering cannot change the result.
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   // Next-state logic; ACK in WAIT takes priority over the timeout.
   always_comb begin
      // NOTE: state_nx gets its default before the case so every path assigns
      // it and no latch is inferred.
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (SETUP_CYC > 0) state_nx = S_SETUP;
               else               state_nx = S_WAIT;
            end
         end
         S_SETUP: if (setup_last) state_nx = S_WAIT;
         S_WAIT: begin
            if (ack)         state_nx = S_DONE;
            else if (to_hit) state_nx = S_ERR;
         end
         S_DONE:  if (ACK_N) state_nx = S_IDLE;
         S_ERR:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Datapath latches, wait-state/timeout counters and the sticky error flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr          <= 1'b0;
         done_first  <= 1'b0;
         setup_cnt   <= '0;
         to_cnt      <= '0;
         bus_addr    <= '0;
         bus_dout    <= '0;
         rdata       <= '0;
         timeout_err <= 1'b0;
      end else begin
         done_first <= (state == S_WAIT) && ack;

         if (state == S_IDLE && accept) begin
            bus_addr <= addr_in;
            bus_dout <= wdata_in;
            wr       <= MW;
         end

         if (state == S_WAIT && ack && !wr) rdata <= bus_din;

         if (state == S_SETUP) setup_cnt <= setup_cnt + 4'd1;
         else                  setup_cnt <= '0;

         // Cleared outside WAIT so it always starts from zero on WAIT entry.
         if (state != S_WAIT)  to_cnt <= '0;
         else if (ACK_N)       to_cnt <= to_cnt + 1'b1;

         // Set has priority over clear.
         if (state == S_WAIT && ACK_N && to_hit)  timeout_err <= 1'b1;
         else if (state == S_IDLE && err_clr)     timeout_err <= 1'b0;
      end
   end

   // Bus strobes and status decode from registered state only (busy also uses
   // ACK_N so the core advances on the ACK edge).
   assign AS_N  = (state != S_WAIT);
   assign WR_N  = ~((state == S_WAIT) & wr);
   assign busy  = (state == S_SETUP) | ((state == S_WAIT) & ACK_N);
   assign done  = (state == S_ERR) | ((state == S_DONE) & done_first);
   assign STATE = state;

endmodule

// File: tb/tb_dlx_bus_mac.sv
// Testbench for dlx_bus_mac. Two instances (SETUP_CYC=0 and SETUP_CYC=2, both
// TIMEOUT=4) are driven with their own inputs. Each transaction's expected
// cycle-by-cycle bus behaviour is derived from the access timeline: setup
// length, ACK delay, timeout length and slave release time.
module tb_dlx_bus_mac;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int TMO  = 4;
   localparam int TO_W = 8;

   logic clk;

   logic          reset    [2];
   logic          req      [2];
   logic          mr       [2];
   logic          mw       [2];
   logic [AW-1:0] addr_in  [2];
   logic [DW-1:0] wdata_in [2];
   logic          ack_n    [2];
   logic [DW-1:0] bus_din  [2];
   logic          err_clr  [2];
   logic          as_n     [2];
   logic          wr_n     [2];
   logic [AW-1:0] bus_addr [2];
   logic [DW-1:0] bus_dout [2];
   logic [DW-1:0] rdata    [2];
   logic          busy     [2];
   logic          done     [2];
   logic          terr     [2];
   logic [2:0]    state_o  [2];

   int n_vec = 0;
   int n_err = 0;

   // Reference model state that persists across transactions.
   logic [DW-1:0] exp_rdata [2];
   logic          exp_terr  [2];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   dlx_bus_mac #(.AW(AW), .DW(DW), .SETUP_CYC(0), .TIMEOUT(TMO), .TO_W(TO_W)) u_dut_s0 (
      .clk(clk), .reset(reset[0]), .REQ(req[0]), .MR(mr[0]), .MW(mw[0]),
      .addr_in(addr_in[0]), .wdata_in(wdata_in[0]), .ACK_N(ack_n[0]),
      .bus_din(bus_din[0]), .err_clr(err_clr[0]), .AS_N(as_n[0]), .WR_N(wr_n[0]),
      .bus_addr(bus_addr[0]), .bus_dout(bus_dout[0]), .rdata(rdata[0]),
      .busy(busy[0]), .done(done[0]), .timeout_err(terr[0]), .STATE(state_o[0])
   );

   dlx_bus_mac #(.AW(AW), .DW(DW), .SETUP_CYC(2), .TIMEOUT(TMO), .TO_W(TO_W)) u_dut_s2 (
      .clk(clk), .reset(reset[1]), .REQ(req[1]), .MR(mr[1]), .MW(mw[1]),
      .addr_in(addr_in[1]), .wdata_in(wdata_in[1]), .ACK_N(ack_n[1]),
      .bus_din(bus_din[1]), .err_clr(err_clr[1]), .AS_N(as_n[1]), .WR_N(wr_n[1]),
      .bus_addr(bus_addr[1]), .bus_dout(bus_dout[1]), .rdata(rdata[1]),
      .busy(busy[1]), .done(done[1]), .timeout_err(terr[1]), .STATE(state_o[1])
   );

   function automatic int setup_of(input int i);
      return (i == 0) ? 0 : 2;
   endfunction

   // One access on instance i. k = ACK delay in cycles after AS_N falls
   // (k >= TMO means the slave never answers); hold = extra cycles the slave
   // keeps ACK_N low after DONE entry; req_in_done re-raises REQ during DONE.
   task automatic run_txn(input int i, input logic r, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [DW-1:0] din, input int k, input int hold,
                          input bit req_in_done, input string tag);
      int            s, wcyc, last;
      bit            abort, in_done;
      logic [2:0]    e_state;
      logic          e_as, e_wr, e_busy, e_done, e_terr;
      logic [7:0]    e_vec, o_vec;
      logic [DW-1:0] e_rdata;
      s       = setup_of(i);
      abort   = (k >= TMO);
      wcyc    = abort ? TMO : k + 1;
      last    = abort ? s + TMO + 1 : s + k + hold + 2;
      e_rdata = (abort || w) ? exp_rdata[i] : din;

      @(negedge clk);
      req[i] = 1'b1; mr[i] = r; mw[i] = w;
      addr_in[i] = a; wdata_in[i] = wd; ack_n[i] = 1'b1; bus_din[i] = $urandom;
      @(posedge clk);
      for (int j = 0; j <= last; j++) begin
         #1;
         in_done     = !abort && (j >= s + k + 1) && (j <= s + k + 1 + hold);
         req[i]      = req_in_done && in_done;
         mr[i]       = 1'b1;
         mw[i]       = 1'($urandom);
         addr_in[i]  = $urandom;
         wdata_in[i] = $urandom;
         ack_n[i]    = !(!abort && (j >= s + k) && (j <= s + k + hold));
         bus_din[i]  = (!abort && j == s + k) ? din : $urandom;
         #1;
         e_as = 1'b1; e_wr = 1'b1; e_busy = 1'b0; e_done = 1'b0;
         if (j < s) begin
            e_state = 3'd1; e_busy = 1'b1;
         end else if (j < s + wcyc) begin
            e_state = 3'd2; e_as = 1'b0; e_wr = ~w; e_busy = ack_n[i];
         end else if (abort) begin
            if (j == s + wcyc) begin e_state = 3'd4; e_done = 1'b1; end
            else               e_state = 3'd0;
         end else if (in_done) begin
            e_state = 3'd3; e_done = (j == s + k + 1);
         end else begin
            e_state = 3'd0;
         end
         e_terr = exp_terr[i] | (abort && j >= s + wcyc);
         e_vec  = {e_state, e_as, e_wr, e_busy, e_done, e_terr};
         o_vec  = {state_o[i], as_n[i], wr_n[i], busy[i], done[i], terr[i]};
         n_vec++;
         if (o_vec !== e_vec || bus_addr[i] !== a || bus_dout[i] !== wd) begin
            n_err++;
            $display("FAIL %s[dut%0d] cyc %0d: got st=%0d as=%b wr=%b busy=%b done=%b terr=%b addr=%h dout=%h, expected st=%0d as=%b wr=%b busy=%b done=%b terr=%b addr=%h dout=%h",
                     tag, i, j, o_vec[7:5], o_vec[4], o_vec[3], o_vec[2], o_vec[1], o_vec[0],
                     bus_addr[i], bus_dout[i], e_state, e_as, e_wr, e_busy, e_done, e_terr, a, wd);
         end
         if (j < last) @(posedge clk);
      end
      n_vec++;
      if (rdata[i] !== e_rdata) begin
         n_err++;
         $display("FAIL %s[dut%0d] rdata: got %h, expected %h", tag, i, rdata[i], e_rdata);
      end
      req[i]       = 1'b0;
      exp_rdata[i] = e_rdata;
      exp_terr[i]  = exp_terr[i] | abort;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) reset[i] = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         n_vec++;
         if ({state_o[i], as_n[i], wr_n[i], busy[i], done[i], terr[i]} !== 8'b000_11_000 ||
             bus_addr[i] !== '0 || bus_dout[i] !== '0 || rdata[i] !== '0) begin
            n_err++;
            $display("FAIL reset[dut%0d]: got st=%0d as=%b wr=%b busy=%b done=%b terr=%b addr=%h dout=%h rdata=%h, expected all idle/zero",
                     i, state_o[i], as_n[i], wr_n[i], busy[i], done[i], terr[i], bus_addr[i], bus_dout[i], rdata[i]);
         end
         exp_rdata[i] = '0;
         exp_terr[i]  = 1'b0;
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) reset[i] = 1'b0;
   endtask

   task automatic test_ignored_req();
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin req[i] = 1'b1; mr[i] = 1'b0; mw[i] = 1'b0; end
      repeat (3) begin
         @(posedge clk); #1;
         for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (state_o[i] !== 3'd0 || as_n[i] !== 1'b1 || busy[i] !== 1'b0) begin
               n_err++;
               $display("FAIL ignored_req[dut%0d]: got st=%0d as=%b busy=%b, expected st=0 as=1 busy=0",
                        i, state_o[i], as_n[i], busy[i]);
            end
         end
      end
      for (int i = 0; i < 2; i++) req[i] = 1'b0;
   endtask

   task automatic test_read_s0();
      run_txn(0, 1'b1, 1'b0, 32'h0000_0100, $urandom, 32'hDEAD_BEEF, 2, 0, 1'b0, "read_s0");
   endtask

   task automatic test_write_s2();
      run_txn(1, 1'b1, 1'b0, $urandom, $urandom, 32'hCAFE_F00D, 0, 0, 1'b0, "read_s2");
      run_txn(1, 1'b0, 1'b1, $urandom, 32'h1234_5678, $urandom, 1, 0, 1'b0, "write_s2");
   endtask

   task automatic test_err_clr(input int i);
      @(negedge clk);
      err_clr[i] = 1'b1;
      @(posedge clk); #1;
      err_clr[i] = 1'b0;
      n_vec++;
      if (terr[i] !== 1'b0) begin
         n_err++;
         $display("FAIL err_clr[dut%0d]: got timeout_err=%b, expected 0", i, terr[i]);
      end
      exp_terr[i] = 1'b0;
   endtask

   task automatic test_timeout();
      for (int i = 0; i < 2; i++) begin
         run_txn(i, 1'b1, 1'b0, $urandom, $urandom, $urandom, TMO, 0, 1'b0, "timeout");
         repeat (2) begin
            @(posedge clk); #1;
            n_vec++;
            if (terr[i] !== 1'b1 || state_o[i] !== 3'd0 || done[i] !== 1'b0) begin
               n_err++;
               $display("FAIL timeout_sticky[dut%0d]: got terr=%b st=%0d done=%b, expected terr=1 st=0 done=0",
                        i, terr[i], state_o[i], done[i]);
            end
         end
         test_err_clr(i);
      end
   endtask

   task automatic test_ack_last();
      for (int i = 0; i < 2; i++)
         run_txn(i, 1'b1, 1'b0, $urandom, $urandom, $urandom, TMO - 1, 0, 1'b0, "ack_last");
   endtask

   task automatic test_slow_release();
      run_txn(0, 1'b1, 1'b0, $urandom, $urandom, $urandom, 1, 3, 1'b1, "slow_release");
      run_txn(1, 1'b0, 1'b1, $urandom, $urandom, $urandom, 0, 3, 1'b1, "slow_release");
   endtask

   task automatic test_reset_mid_wait();
      @(negedge clk);
      req[0] = 1'b1; mr[0] = 1'b1; mw[0] = 1'b0; addr_in[0] = $urandom; ack_n[0] = 1'b1;
      @(posedge clk); #1;
      req[0] = 1'b0;
      @(posedge clk); #1;
      n_vec++;
      if (state_o[0] !== 3'd2 || as_n[0] !== 1'b0) begin
         n_err++;
         $display("FAIL mid_wait_pre[dut0]: got st=%0d as=%b, expected st=2 as=0", state_o[0], as_n[0]);
      end
      reset[0] = 1'b1;
      @(posedge clk); #1;
      reset[0] = 1'b0;
      n_vec++;
      if (state_o[0] !== 3'd0 || as_n[0] !== 1'b1 || wr_n[0] !== 1'b1 || done[0] !== 1'b0 ||
          rdata[0] !== '0 || bus_addr[0] !== '0) begin
         n_err++;
         $display("FAIL mid_wait_reset[dut0]: got st=%0d as=%b wr=%b done=%b rdata=%h addr=%h, expected st=0 as=1 wr=1 done=0 rdata=0 addr=0",
                  state_o[0], as_n[0], wr_n[0], done[0], rdata[0], bus_addr[0]);
      end
      @(posedge clk); #1;
      n_vec++;
      if (state_o[0] !== 3'd0 || done[0] !== 1'b0) begin
         n_err++;
         $display("FAIL mid_wait_after[dut0]: got st=%0d done=%b, expected st=0 done=0", state_o[0], done[0]);
      end
      exp_rdata[0] = '0;
      exp_terr[0]  = 1'b0;
      run_txn(0, 1'b1, 1'b1, $urandom, $urandom, $urandom, 1, 0, 1'b0, "mr_mw_priority");
   endtask

   task automatic test_random();
      int   k, hold;
      logic r, w;
      bit   rid;
      for (int n = 0; n < 24; n++) begin
         r    = 1'($urandom);
         w    = 1'($urandom);
         if (!r && !w) r = 1'b1;
         k    = $urandom_range(0, 5);
         hold = $urandom_range(0, 2);
         rid  = 1'($urandom);
         if (exp_terr[n % 2] && $urandom_range(0, 1) == 1) test_err_clr(n % 2);
         run_txn(n % 2, r, w, $urandom, $urandom, $urandom, k, hold, rid, "random");
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         reset[i] = 1'b1; req[i] = 1'b0; mr[i] = 1'b0; mw[i] = 1'b0;
         addr_in[i] = '0; wdata_in[i] = '0; ack_n[i] = 1'b1; bus_din[i] = '0;
         err_clr[i] = 1'b0; exp_rdata[i] = '0; exp_terr[i] = 1'b0;
      end
      test_reset();
      test_ignored_req();
      test_read_s0();
      test_write_s2();
      test_timeout();
      test_ack_last();
      test_slow_release();
      test_reset_mid_wait();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
